// File: rtl/triangle_sequencer.sv
// triangle_sequencer
//   Sequences an external N-bit triangle generator: issues a one-cycle clear
//   strobe, then paced step-enable strobes, for a programmed number of full
//   triangle periods (or until stopped).
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous reset, active low
//   start         one-cycle run request, honoured only when idle
//   stop          abort request, honoured only while running
//   period        clk cycles per triangle step (0 treated as 1), sampled at start
//   cycles        triangle periods per run (0 = run until stop), sampled at start
//   tri_clr       synchronous clear strobe to the generator
//   tri_ena       step-enable strobe to the generator
//   busy          high whenever a run is in progress (not idle)
//   done          one-cycle completion pulse
//   aborted       qualifies done: run ended by stop; held until next start
//   periods_done  completed triangle periods in the current or last run
module triangle_sequencer #(
    parameter int unsigned N     = 8,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] period,
    input  logic [CNT_W-1:0] cycles,
    output logic             tri_clr,
    output logic             tri_ena,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] periods_done
);

    typedef enum logic [1:0] {StIdle, StClear, StRun, StFinish} state_e;

    // A full up/down triangle on an N-bit generator takes 2^(N+1)-2 steps;
    // this is the step index of the last one.
    localparam logic [N:0] StepLast = {{N{1'b1}}, 1'b0} - (N+1)'(1);

    state_e           state_q;
    logic [DIV_W-1:0] period_q;
    logic [CNT_W-1:0] cycles_q;
    logic [DIV_W-1:0] presc_q;
    logic [N:0]       step_q;

    logic [DIV_W-1:0] per_last;
    logic [DIV_W-1:0] presc_nxt;
    logic [CNT_W-1:0] pd_inc;
    logic             period_wrap;
    logic             run_complete;

    always_comb begin
        per_last     = period_q - DIV_W'(1);
        presc_nxt    = (presc_q == per_last) ? '0 : presc_q + DIV_W'(1);
        pd_inc       = periods_done + CNT_W'(1);
        period_wrap  = (step_q == StepLast);
        // The step currently being issued finishes the final requested period.
        run_complete = tri_ena && period_wrap && (cycles_q != '0) && (pd_inc == cycles_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            period_q     <= '0;
            cycles_q     <= '0;
            presc_q      <= '0;
            step_q       <= '0;
            tri_clr      <= 1'b0;
            tri_ena      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            periods_done <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StClear;
                        period_q     <= (period == '0) ? DIV_W'(1) : period;
                        cycles_q     <= cycles;
                        presc_q      <= '0;
                        step_q       <= '0;
                        periods_done <= '0;
                        aborted      <= 1'b0;
                        tri_clr      <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                StClear: begin
                    state_q <= StRun;
                    tri_clr <= 1'b0;
                    presc_q <= '0;
                    // tri_ena tracks "prescaler at terminal count" one cycle
                    // ahead so the output stays registered.
                    tri_ena <= (per_last == '0);
                end
                StRun: begin
                    if (tri_ena) begin
                        if (period_wrap) begin
                            step_q       <= '0;
                            periods_done <= pd_inc;
                        end else begin
                            step_q <= step_q + (N+1)'(1);
                        end
                    end
                    // Completion takes priority over a coincident stop.
                    if (run_complete) begin
                        state_q <= StFinish;
                        tri_ena <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b0;
                    end else if (stop) begin
                        state_q <= StFinish;
                        tri_ena <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        presc_q <= presc_nxt;
                        tri_ena <= (presc_nxt == per_last);
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_sequencer.sv
module tb_triangle_sequencer;

    localparam int N     = 4;
    localparam int DIV_W = 16;
    localparam int CNT_W = 8;
    localparam int STEPS = (1 << (N + 1)) - 2;  // steps per triangle period

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] period;
    logic [CNT_W-1:0] cycles;
    logic             tri_clr;
    logic             tri_ena;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] periods_done;

    int n_checks = 0;
    int n_fail   = 0;

    triangle_sequencer #(
        .N    (N),
        .DIV_W(DIV_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .cycles      (cycles),
        .tri_clr     (tri_clr),
        .tri_ena     (tri_ena),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .periods_done(periods_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One run checked cycle by cycle against an arithmetic model:
    // RUN cycle k carries a step iff (k+1) % p == 0; steps before k = k / p;
    // the natural end is the last step of period number c.
    task automatic run(input int pin, input int cin, input int stop_at, input int dist_at,
                       input int rst_at);
        int p;
        int k_end;
        int last;
        bit ab;
        p     = (pin == 0) ? 1 : pin;
        k_end = (cin == 0) ? 32'h7fff_ffff : cin * STEPS * p - 1;
        last  = k_end;
        ab    = 1'b0;
        if (stop_at >= 0 && stop_at < k_end) begin
            last = stop_at;
            ab   = 1'b1;
        end

        period = DIV_W'(pin);
        cycles = CNT_W'(cin);
        start  = 1'b1;
        tick;
        start = 1'b0;
        chk("clr_strobe", tri_clr, 1);
        chk("clr_no_ena", tri_ena, 0);
        chk("clr_busy", busy, 1);
        chk("clr_periods", periods_done, 0);
        tick;

        for (int k = 0; k <= last; k++) begin
            chk("run_ena", tri_ena, ((k + 1) % p == 0) ? 1 : 0);
            chk("run_clr", tri_clr, 0);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_periods", periods_done, ((k / p) / STEPS) % 256);
            if (k == rst_at) begin
                stop  = 1'b0;
                start = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("arst_ena", tri_ena, 0);
                chk("arst_busy", busy, 0);
                chk("arst_periods", periods_done, 0);
                tick;
                tick;
                chk("arst_no_done", done, 0);
                chk("arst_idle", busy, 0);
                rst = 1'b1;
                tick;
                chk("arst_stays_idle", busy, 0);
                return;
            end
            stop = (k == stop_at);
            if (k == dist_at) begin
                start  = 1'b1;
                period = DIV_W'($urandom);
                cycles = CNT_W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick;
        end
        stop  = 1'b0;
        start = 1'b0;
        chk("fin_done", done, 1);
        chk("fin_aborted", aborted, ab);
        chk("fin_no_ena", tri_ena, 0);
        chk("fin_busy", busy, 1);
        chk("fin_periods", periods_done, (((last + 1) / p) / STEPS) % 256);
        tick;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_aborted_hold", aborted, ab);
        chk("idle_periods_hold", periods_done, (((last + 1) / p) / STEPS) % 256);
    endtask

    initial begin
        int p;
        int c;
        int s;
        rst    = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        period = DIV_W'(1);
        cycles = CNT_W'(2);
        #12;
        chk("rst_clr", tri_clr, 0);
        chk("rst_ena", tri_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_periods", periods_done, 0);
        rst = 1'b1;
        tick;

        // stop while idle is ignored
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("idle_stop_busy", busy, 0);
        chk("idle_stop_done", done, 0);

        run(1, 2, -1, -1, -1);   // back-to-back steps, two periods
        run(3, 1, -1, -1, -1);   // paced steps, one period
        run(0, 0, 44, -1, -1);   // free run, stopped after 45 steps
        run(1, 1, 29, -1, -1);   // stop coincides with final step
        run(2, 1, 59, -1, -1);
        run(2, 2, -1, -1, 20);   // asynchronous reset mid-run
        run(2, 1, -1, -1, -1);   // full run after reset
        run(2, 1, -1, 7, -1);    // start/period/cycles disturbed mid-run
        run(1, 1, -1, 29, -1);

        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(0, 4);
            c = $urandom_range(0, 3);
            if (c == 0) s = $urandom_range(0, 150);
            else if ($urandom_range(0, 1) == 1)
                s = $urandom_range(0, c * STEPS * ((p == 0) ? 1 : p) + 5);
            else s = -1;
            run(p, c, s, $urandom_range(0, 60), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/triangle_sequencer.md
TRIANGLE_SEQUENCER -- requirements
Module: triangle_sequencer

Interface
REQ-001 Parameter N, default 8: bit width of the sequenced triangle generator.
REQ-002 Parameter DIV_W, default 16: width of the step-rate prescaler.
REQ-003 Parameter CNT_W, default 8: width of the wave-period count.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-006 start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 stop  input  1  request to abort a run; honoured only in RUN.
REQ-008 period  input  DIV_W  clk cycles per triangle step; sampled at start.
REQ-009 cycles  input  CNT_W  full triangle periods per run; sampled at start; 0 = run until stop.
REQ-010 tri_clr  output  1  synchronous clear strobe to the generator's register.
REQ-011 tri_ena  output  1  step-enable strobe to the generator.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 aborted  output  1  valid with done; 1 when the run ended by stop.
REQ-015 periods_done  output  CNT_W  count of completed triangle periods in the current or last run.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN, FINISH.
REQ-017 IDLE: start=1 -> CLEAR; latch period (0 treated as 1) and cycles; clear periods_done, prescaler, step counter.
REQ-018 CLEAR: SHALL last exactly one cycle with tri_clr=1, tri_ena=0, then -> RUN.
REQ-019 RUN: prescaler counts 0..period-1; tri_ena=1 for exactly one cycle when prescaler = period-1, then prescaler wraps to 0.
REQ-020 First tri_ena SHALL occur period cycles after entering RUN (period=1: first RUN cycle, then every cycle).
REQ-021 Step counter (N+1 bits) SHALL increment on each tri_ena; one triangle period = 2^(N+1)-2 steps.
REQ-022 On the tri_ena completing a period: step counter -> 0, periods_done increments (wraps modulo 2^CNT_W).
REQ-023 cycles!=0 and periods_done reaches cycles on that tri_ena -> FINISH next cycle, aborted=0.
REQ-024 stop=1 in RUN -> FINISH next cycle, aborted=1; tri_ena in that same cycle SHALL still be issued if due.
REQ-025 stop and the final completing tri_ena in the same cycle -> aborted=0 (completion wins).
REQ-026 FINISH: done=1 for one cycle, tri_ena=0, then -> IDLE; aborted holds until next start.
REQ-027 start outside IDLE and stop outside RUN SHALL be ignored; period/cycles changes after start SHALL have no effect.
REQ-028 tri_clr and tri_ena SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered (no combinational input-to-output path).

Reset
REQ-030 rst=0 SHALL immediately force IDLE; tri_clr=0, tri_ena=0, busy=0, done=0, aborted=0, periods_done=0, prescaler and step counter = 0.
REQ-031 Reset mid-run SHALL abandon the run without a done pulse; first start after rst=1 SHALL behave as from power-up.

Verification
REQ-032 N=4, period=1, cycles=2, start pulse -> tri_clr one cycle, then 60 consecutive tri_ena, periods_done 1 after 30th, done=1 aborted=0 one cycle after 60th, busy=0 next.
REQ-033 N=4, period=3, cycles=1 -> tri_ena every 3rd clk, first 3 clks after CLEAR, 30 pulses total, done after 90 RUN cycles.
REQ-034 N=4, period=0, cycles=0 -> tri_ena every cycle indefinitely; stop after 45 pulses -> done=1 aborted=1, periods_done=1.
REQ-035 Stop asserted on the same cycle as the 30th tri_ena with cycles=1 -> done with aborted=0, periods_done=1.
REQ-036 rst=0 asynchronously mid-RUN (between clock edges) -> tri_ena/busy drop without waiting for clk, no done pulse; new start runs a full, correct sequence.
REQ-037 start pulsed during RUN and period/cycles changed mid-run -> no effect on tri_ena timing or run length.
